// File: rtl/nibble_seq_mul8.sv
// Sequential 8x8 unsigned multiplier built from an external combinational 4x4 core.
// Optional exact-product error reporting is enabled with `define NSM_EXACT_CHECK_EN.
module nibble_seq_mul8 #(
    parameter int SKIP_ZERO = 1,
    parameter int RES_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] result,
    output logic             busy,
    output logic [3:0]       pp_a,
    output logic [3:0]       pp_b,
    input  logic [7:0]       pp_r
`ifdef NSM_EXACT_CHECK_EN
    ,
    output logic [RES_W-1:0] err_abs,
    output logic             err_nz
`endif
);

    // Handshakes: a transfer happens on any rising edge where valid and ready are
    // both high; valid never depends on ready, and result is held while out_valid waits.

    if (RES_W != 16) begin : g_bad_res_w
        $error("nibble_seq_mul8: RES_W must be 16");
    end

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  idx;
    logic [7:0]  a_q, b_q;
    logic [15:0] acc, term, sum;
    logic        accept, skip;

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
        accept    = in_valid & in_ready;
        skip      = (SKIP_ZERO != 0) && ((a == 8'd0) || (b == 8'd0));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = skip ? DONE : MUL;
            MUL:  if (idx == 2'd3) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Nibble selection: low*low, low*high, high*low, high*high.
    always_comb begin
        pp_a = 4'h0;
        pp_b = 4'h0;
        if (state == MUL) begin
            pp_a = idx[1] ? a_q[7:4] : a_q[3:0];
            pp_b = idx[0] ? b_q[7:4] : b_q[3:0];
        end
    end

    always_comb begin
        case (idx)
            2'd0:    term = {8'h00, pp_r};
            2'd3:    term = {pp_r, 8'h00};
            default: term = {4'h0, pp_r, 4'h0};
        endcase
        sum = acc + term;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= 2'd0;
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            acc    <= 16'h0000;
            result <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    a_q <= a;
                    b_q <= b;
                    acc <= 16'h0000;
                    idx <= 2'd0;
                    if (skip) result <= '0;
                end
                MUL: begin
                    acc <= sum;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) result <= sum;
                end
                default: ;
            endcase
        end
    end

`ifdef NSM_EXACT_CHECK_EN
    logic [15:0] exact_q, diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            exact_q <= 16'h0000;
        end else if (accept) begin
            exact_q <= 16'(a) * 16'(b);
        end
    end

    always_comb begin
        diff    = (result >= exact_q) ? (result - exact_q) : (exact_q - result);
        err_abs = out_valid ? diff : '0;
        err_nz  = (err_abs != '0);
    end
`endif

endmodule
